// File: rtl/convnet_pkg.sv
// Shared constants, FSM state encoding and the tile-to-SRAM placement helpers
// used by the conv-net pooling stage.
package convnet_pkg;

  // Activations per SRAM word (4 channels x one 2x2 tile) and the matching word width
  localparam int ACT_IDX = 16;
  localparam int WORD_BW = 192;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Bank holding tile (ty,tx): the low bits of the tile coordinates
  function automatic logic [1:0] tile_bank(input logic [3:0] ty, input logic [3:0] tx);
    return {ty[0], tx[0]};
  endfunction

  // Word address of tile (ty,tx) inside its bank for a map that is dim tiles wide
  function automatic logic [5:0] tile_addr(input logic [3:0] ty, input logic [3:0] tx,
                                           input logic [4:0] dim);
    int r;
    r = int'(ty[3:1]) * int'(dim[4:1]) + int'(tx[3:1]);
    return r[5:0];
  endfunction

endpackage

// File: rtl/max4_signed.sv
// Combinational signed maximum of the four activations of one channel in a 2x2 tile.
module max4_signed #(
  parameter int BW_PER_ACT = 12
) (
  input  logic signed [BW_PER_ACT-1:0] a0,
  input  logic signed [BW_PER_ACT-1:0] a1,
  input  logic signed [BW_PER_ACT-1:0] a2,
  input  logic signed [BW_PER_ACT-1:0] a3,
  output logic signed [BW_PER_ACT-1:0] y
);

  logic signed [BW_PER_ACT-1:0] m01;
  logic signed [BW_PER_ACT-1:0] m23;

  // Two-level compare tree; on a tie both operands carry the same value
  always_comb begin
    m01 = (a0 > a1) ? a0 : a1;
    m23 = (a2 > a3) ? a2 : a3;
    y   = (m01 > m23) ? m01 : m23;
  end

endmodule

// File: rtl/maxpool2_stage.sv
// 2x2 / stride-2 max-pool stage: streams the conv1 map out of SRAM group B one
// tile per cycle and writes the pooled map into SRAM group A in tile format.
// Optional build macro RELU_EN: clamp negative pooled values to zero before writing.
module maxpool2_stage
  import convnet_pkg::*;
#(
  parameter int CH_NUM       = 4,
  parameter int ACT_PER_ADDR = 4,
  parameter int BW_PER_ACT   = 12,
  parameter int TILE_DIM     = 12
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      valid,
  output logic [5:0]                                sram_raddr_b0,
  output logic [5:0]                                sram_raddr_b1,
  output logic [5:0]                                sram_raddr_b2,
  output logic [5:0]                                sram_raddr_b3,
  input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_b0,
  input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_b1,
  input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_b2,
  input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_b3,
  output logic                                      sram_wen_a0,
  output logic                                      sram_wen_a1,
  output logic                                      sram_wen_a2,
  output logic                                      sram_wen_a3,
  output logic [CH_NUM*ACT_PER_ADDR-1:0]            sram_wordmask_a,
  output logic [5:0]                                sram_waddr_a,
  output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_wdata_a
);

  localparam int         NACT    = CH_NUM * ACT_PER_ADDR;
  localparam int         WBW     = NACT * BW_PER_ACT;
  localparam logic [3:0] LAST    = 4'(TILE_DIM - 1);
  localparam logic [4:0] DIM_IN  = 5'(TILE_DIM);
  localparam logic [4:0] DIM_OUT = 5'(TILE_DIM / 2);

  function automatic logic signed [BW_PER_ACT-1:0] relu_clamp(
    input logic signed [BW_PER_ACT-1:0] v);
`ifdef RELU_EN
    return v[BW_PER_ACT-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  state_t      state;
  logic [3:0]  ty, tx;
  logic        drain_cnt;
  logic [1:0]  rd_bank;
  logic [5:0]  rd_addr;
  logic [5:0]  raddr [4];
  logic        vld_p0, vld_p1;
  logic [3:0]  ty_p0, tx_p0, ty_p1, tx_p1;
  logic [1:0]  bank_p1;
  logic [1:0]  wr_bank;
  logic [5:0]  wr_addr;
  logic [WBW-1:0]  rdata_sel;
  logic [WBW-1:0]  wdata_nxt;
  logic [NACT-1:0] mask_nxt;
  logic [3:0]  wen;
  logic signed [BW_PER_ACT-1:0] pooled [CH_NUM];

  assign rd_bank = tile_bank(ty, tx);
  assign rd_addr = tile_addr(ty, tx, DIM_IN);

  // Sequencer: walks the input tiles in raster order, then drains the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ty        <= '0;
      tx        <= '0;
      drain_cnt <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          valid <= 1'b0;
          if (start) begin
            state <= ST_RUN;
            ty    <= '0;
            tx    <= '0;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (tx == LAST) begin
            tx <= '0;
            if (ty == LAST) begin
              state     <= ST_DRAIN;
              drain_cnt <= 1'b0;
            end else begin
              ty <= ty + 4'd1;
            end
          end else begin
            tx <= tx + 4'd1;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            valid <= 1'b1;
          end
        end
        ST_DONE: begin
          valid <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // p0: issue the read for the current tile; only the addressed bank moves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) raddr[b] <= '0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (state == ST_RUN && rd_bank == 2'(b)) raddr[b] <= rd_addr;
      vld_p0 <= (state == ST_RUN);
      vld_p1 <= vld_p0;
    end
  end

  // p0 -> p1: tile coordinates follow the read through the SRAM latency
  always_ff @(posedge clk) begin
    ty_p0 <= ty;
    tx_p0 <= tx;
    ty_p1 <= ty_p0;
    tx_p1 <= tx_p0;
  end

  assign sram_raddr_b0 = raddr[0];
  assign sram_raddr_b1 = raddr[1];
  assign sram_raddr_b2 = raddr[2];
  assign sram_raddr_b3 = raddr[3];

  // Input bank of a tile equals the pooled pixel's position inside its output tile
  assign bank_p1 = {ty_p1[0], tx_p1[0]};
  assign wr_bank = tile_bank({1'b0, ty_p1[3:1]}, {1'b0, tx_p1[3:1]});
  assign wr_addr = tile_addr({1'b0, ty_p1[3:1]}, {1'b0, tx_p1[3:1]}, DIM_OUT);

  // p1: select the returning word from the bank that was read
  always_comb begin
    rdata_sel = sram_rdata_b0;
    unique case (bank_p1)
      2'd0: rdata_sel = sram_rdata_b0;
      2'd1: rdata_sel = sram_rdata_b1;
      2'd2: rdata_sel = sram_rdata_b2;
      2'd3: rdata_sel = sram_rdata_b3;
      default: rdata_sel = sram_rdata_b0;
    endcase
  end

  for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
    max4_signed #(.BW_PER_ACT(BW_PER_ACT)) u_max (
      .a0 (rdata_sel[BW_PER_ACT*(NACT-1-ch*ACT_PER_ADDR)   +: BW_PER_ACT]),
      .a1 (rdata_sel[BW_PER_ACT*(NACT-2-ch*ACT_PER_ADDR)   +: BW_PER_ACT]),
      .a2 (rdata_sel[BW_PER_ACT*(NACT-3-ch*ACT_PER_ADDR)   +: BW_PER_ACT]),
      .a3 (rdata_sel[BW_PER_ACT*(NACT-4-ch*ACT_PER_ADDR)   +: BW_PER_ACT]),
      .y  (pooled[ch])
    );
  end

  // Place each channel's pooled value in its slot and open only those mask bits
  always_comb begin
    wdata_nxt = '0;
    mask_nxt  = '1;
    for (int ch = 0; ch < CH_NUM; ch++)
      for (int p = 0; p < ACT_PER_ADDR; p++)
        if (bank_p1 == 2'(p)) begin
          wdata_nxt[BW_PER_ACT*(NACT-1-(ch*ACT_PER_ADDR+p)) +: BW_PER_ACT] = relu_clamp(pooled[ch]);
          mask_nxt[NACT-1-(ch*ACT_PER_ADDR+p)] = 1'b0;
        end
  end

  // p2: registered write port; idle cycles keep every bank disabled and fully masked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen             <= 4'hF;
      sram_wordmask_a <= '1;
      sram_waddr_a    <= '0;
      sram_wdata_a    <= '0;
    end else if (vld_p1) begin
      wen             <= ~(4'b0001 << wr_bank);
      sram_wordmask_a <= mask_nxt;
      sram_waddr_a    <= wr_addr;
      sram_wdata_a    <= wdata_nxt;
    end else begin
      wen             <= 4'hF;
      sram_wordmask_a <= '1;
      sram_wdata_a    <= '0;
    end
  end

  assign sram_wen_a0 = wen[0];
  assign sram_wen_a1 = wen[1];
  assign sram_wen_a2 = wen[2];
  assign sram_wen_a3 = wen[3];

endmodule

// File: tb/tb_maxpool2_stage.sv
// Scoreboard bench for maxpool2_stage: stimulus pushes the expected group A
// writes, an independent monitor pops and compares every write it observes.
module tb_maxpool2_stage;

  localparam int BW  = 12;
  localparam int WBW = 192;

  typedef struct {
    int           bank;
    int           addr;
    logic [15:0]  mask;
    logic [WBW-1:0] data;
  } wr_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           busy, valid;
  logic [5:0]     raddr_b0, raddr_b1, raddr_b2, raddr_b3;
  logic [WBW-1:0] rdata_b0, rdata_b1, rdata_b2, rdata_b3;
  logic           wen_a0, wen_a1, wen_a2, wen_a3;
  logic [15:0]    wordmask_a;
  logic [5:0]     waddr_a;
  logic [WBW-1:0] wdata_a;

  maxpool2_stage dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .valid(valid),
    .sram_raddr_b0(raddr_b0), .sram_raddr_b1(raddr_b1),
    .sram_raddr_b2(raddr_b2), .sram_raddr_b3(raddr_b3),
    .sram_rdata_b0(rdata_b0), .sram_rdata_b1(rdata_b1),
    .sram_rdata_b2(rdata_b2), .sram_rdata_b3(rdata_b3),
    .sram_wen_a0(wen_a0), .sram_wen_a1(wen_a1),
    .sram_wen_a2(wen_a2), .sram_wen_a3(wen_a3),
    .sram_wordmask_a(wordmask_a), .sram_waddr_a(waddr_a), .sram_wdata_a(wdata_a)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  logic signed [11:0] pix [4][24][24];
  logic [WBW-1:0]     memb [4][64];
  logic [5:0]         exp_ra [4];
  wr_t                wq [$];

  int             first_wr_cyc, last_wr_cyc, last_bank, last_addr, last_mask;
  logic [WBW-1:0] first_word;

  // Group B SRAM: synchronous read, data one cycle after the address
  always @(posedge clk) begin
    rdata_b0 <= memb[0][raddr_b0];
    rdata_b1 <= memb[1][raddr_b1];
    rdata_b2 <= memb[2][raddr_b2];
    rdata_b3 <= memb[3][raddr_b3];
  end

  task automatic check_i(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [WBW-1:0] act, input logic [WBW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic signed [11:0] relu(input logic signed [11:0] v);
`ifdef RELU_EN
    return (v < 0) ? 12'sd0 : v;
`else
    return v;
`endif
  endfunction

  // Pack the pixel map into group B tile words
  task automatic build_mem();
    logic [WBW-1:0] word;
    for (int ty = 0; ty < 12; ty++)
      for (int tx = 0; tx < 12; tx++) begin
        word = '0;
        for (int ch = 0; ch < 4; ch++)
          for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
              word[BW*(15-(ch*4+r*2+c)) +: BW] = pix[ch][2*ty+r][2*tx+c];
        memb[(ty%2)*2 + (tx%2)][(ty/2)*6 + tx/2] = word;
      end
  endtask

  // Golden pooled map, one expected write per output pixel in raster order
  task automatic push_expected();
    wr_t e;
    logic signed [11:0] m;
    int i, oty, otx;
    for (int oy = 0; oy < 12; oy++)
      for (int ox = 0; ox < 12; ox++) begin
        e.data = '0;
        e.mask = 16'hFFFF;
        for (int ch = 0; ch < 4; ch++) begin
          m = pix[ch][2*oy][2*ox];
          for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
              if (pix[ch][2*oy+r][2*ox+c] > m) m = pix[ch][2*oy+r][2*ox+c];
          i = ch*4 + (oy%2)*2 + (ox%2);
          e.data[BW*(15-i) +: BW] = relu(m);
          e.mask[15-i] = 1'b0;
        end
        oty = oy / 2;
        otx = ox / 2;
        e.bank = (oty%2)*2 + (otx%2);
        e.addr = (oty/2)*3 + otx/2;
        wq.push_back(e);
      end
  endtask

  // Monitor: every write on group A is popped against the scoreboard
  always @(negedge clk) begin
    logic [3:0] wen;
    wr_t e;
    int b;
    if (rst_n) begin
      wen = {wen_a3, wen_a2, wen_a1, wen_a0};
      if (wen != 4'hF) begin
        check_i("wen_onehot", $countones(~wen), 1);
        b = 0;
        for (int k = 0; k < 4; k++) if (!wen[k]) b = k;
        if (wq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: bank %0d addr %0d, none expected", b, waddr_a);
        end else begin
          e = wq.pop_front();
          check_i("wr_bank", b, e.bank);
          check_i("wr_addr", int'(waddr_a), e.addr);
          check_i("wr_mask", int'(wordmask_a), int'(e.mask));
          check_w("wr_data", wdata_a, e.data);
        end
        if (first_wr_cyc < 0) begin
          first_wr_cyc = cyc;
          first_word   = wdata_a;
        end
        last_wr_cyc = cyc;
        last_bank   = b;
        last_addr   = int'(waddr_a);
        last_mask   = int'(wordmask_a);
      end else begin
        check_i("idle_mask", int'(wordmask_a), 16'hFFFF);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_i({tag, "_busy"},  int'(busy), 0);
    check_i({tag, "_valid"}, int'(valid), 0);
    check_i({tag, "_wen"},   int'({wen_a3, wen_a2, wen_a1, wen_a0}), 4'hF);
    check_i({tag, "_mask"},  int'(wordmask_a), 16'hFFFF);
    check_i({tag, "_raddr"}, int'({raddr_b3, raddr_b2, raddr_b1, raddr_b0}), 0);
    check_i({tag, "_waddr"}, int'(waddr_a), 0);
    check_w({tag, "_wdata"}, wdata_a, '0);
  endtask

  // One pooling pass; dbl_at re-pulses start mid-run, abort_at drops rst_n
  task automatic run_frame(input int dbl_at, input int abort_at);
    int s, vseen, k, ty, tx;
    logic busy_prev;
    push_expected();
    first_wr_cyc = -1;
    last_wr_cyc  = -1;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    vseen = -1;
    busy_prev = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      start = (n == dbl_at);
      if (n >= 2 && n <= 145) begin
        k  = n - 2;
        ty = k / 12;
        tx = k % 12;
        exp_ra[(ty%2)*2 + tx%2] = 6'((ty/2)*6 + tx/2);
        check_i("raddr_seq", int'({raddr_b3, raddr_b2, raddr_b1, raddr_b0}),
                int'({exp_ra[3], exp_ra[2], exp_ra[1], exp_ra[0]}));
      end
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        wq.delete();
        for (int b = 0; b < 4; b++) exp_ra[b] = '0;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (valid) begin
        vseen = n;
        break;
      end
      busy_prev = busy;
      @(negedge clk);
    end
    start = 1'b0;
    check_i("valid_latency", vseen, 147);
    check_i("busy_at_valid", int'(busy), 0);
    check_i("busy_before_valid", int'(busy_prev), 1);
    @(negedge clk);
    check_i("valid_pulse_width", int'(valid), 0);
    check_i("first_write_latency", first_wr_cyc - s, 4);
    check_i("last_write_with_valid", last_wr_cyc - s, 147);
    check_i("last_bank", last_bank, 3);
    check_i("last_addr", last_addr, 8);
    check_i("last_mask", last_mask, 16'hEEEE);
    check_i("queue_drained", wq.size(), 0);
  endtask

  initial begin
    logic [11:0] exp_ch1;
`ifdef RELU_EN
    exp_ch1 = 12'h000;
`else
    exp_ch1 = 12'hF9C;
`endif
    for (int b = 0; b < 4; b++) exp_ra[b] = '0;
    for (int ch = 0; ch < 4; ch++)
      for (int y = 0; y < 24; y++)
        for (int x = 0; x < 24; x++)
          pix[ch][y][x] = 12'(((x*7 + y*13 + ch*5) % 200) - 100);
    for (int y = 0; y < 24; y++)
      for (int x = 0; x < 24; x++) pix[1][y][x] = -12'sd100;
    pix[0][0][0] = 12'sd5;  pix[0][0][1] = -12'sd3;
    pix[0][1][0] = 12'sd7;  pix[0][1][1] = 12'sd2;
    for (int y = 0; y < 2; y++)
      for (int x = 2; x < 4; x++) pix[2][y][x] = -12'sd2048;
    pix[3][0][4] = 12'sd2047;
    pix[3][1][5] = 12'sd2047;
    build_mem();

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(0, 0);
    check_i("tile00_ch0_pos0", int'(first_word[BW*15 +: BW]), 12'h007);
    check_i("tile00_ch1_pos0", int'(first_word[BW*11 +: BW]), int'(exp_ch1));

    run_frame(11, 0);

    for (int ch = 0; ch < 4; ch++)
      for (int y = 0; y < 24; y++)
        for (int x = 0; x < 24; x++) pix[ch][y][x] = 12'($urandom);
    build_mem();
    run_frame(0, 0);

    run_frame(0, 51);
    run_frame(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
